// File: rtl/spi_pkt_loader_if.sv
// Frame-capture and memory-write signal bundle for spi_pkt_loader.
// slave is the loader's view; master is the SPI/memory/router side.
interface spi_pkt_loader_if #(
   parameter int unsigned ADDR_SIZE = 23
);
   logic [7:0]           rx_byte;
   logic                 rx_valid;
   logic                 frame_act;
   logic                 busy;
   logic [ADDR_SIZE-1:0] mem_ptr;
   logic [31:0]          mem_wdata;
   logic                 mem_w_en;
   logic                 mem_done;
   logic                 pkt_avail;
   logic [ADDR_SIZE-1:0] pkt_begin;
   logic [ADDR_SIZE-1:0] pkt_end;
   logic                 dpr_done;
   logic                 ovf_err;

   modport slave (
      input  rx_byte, rx_valid, frame_act, mem_done, dpr_done,
      output busy, mem_ptr, mem_wdata, mem_w_en, pkt_avail, pkt_begin, pkt_end, ovf_err
   );

   modport master (
      output rx_byte, rx_valid, frame_act, mem_done, dpr_done,
      input  busy, mem_ptr, mem_wdata, mem_w_en, pkt_avail, pkt_begin, pkt_end, ovf_err
   );
endinterface

// File: rtl/spi_pkt_loader.sv
// Packs one SPI frame into little-endian 32-bit words, writes them through a small FIFO
// into the packet buffer, then publishes the packet bounds until the router releases it.
module spi_pkt_loader #(
   parameter int unsigned          ADDR_SIZE  = 23,
   parameter logic [ADDR_SIZE-1:0] BUF_BASE   = '0,
   parameter int unsigned          BUF_WORDS  = 1024,
   parameter int unsigned          FIFO_DEPTH = 4
) (
   input logic              clk,
   input logic              rst_l,
   spi_pkt_loader_if.slave  bus
);
   localparam int unsigned WC_W  = $clog2(BUF_WORDS + 1);
   localparam int unsigned PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {S_IDLE, S_RECV, S_FLUSH, S_PUBLISH, S_HOLD, S_DROP} state_t;

   state_t               r_state, w_next;
   logic                 r_frame_d;
   logic [1:0]           r_lane;
   logic [31:0]          r_asm;
   logic                 r_got;
   logic                 r_push_pend;
   logic [31:0]          r_push_data;
   logic [31:0]          r_fifo [FIFO_DEPTH];
   logic [PW-1:0]        r_wr, r_rd;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_wen;
   logic [ADDR_SIZE-1:0] r_ptr, r_pkt_end;
   logic [31:0]          r_wdata;
   logic [WC_W-1:0]      r_wcount;
   logic                 r_ovf;

   logic                 w_rise, w_push, w_full, w_ovf, w_pop, w_flush_done;
   logic [31:0]          w_occ;

   assign w_rise = bus.frame_act & ~r_frame_d;
   assign w_push = r_push_pend & ((r_state == S_RECV) | (r_state == S_FLUSH));
   assign w_full = (r_cnt == CNT_W'(FIFO_DEPTH));
   // the word already on the memory bus still needs a buffer slot
   assign w_occ  = 32'(r_wcount) + 32'(r_cnt) + 32'(r_wen);
   assign w_ovf  = w_push & (w_full | (w_occ >= BUF_WORDS));
   assign w_pop  = (r_cnt != '0) & ~r_wen & (r_state != S_DROP);
   assign w_flush_done = ~r_push_pend & (r_lane == 2'd0) & (r_cnt == '0) & ~r_wen;

   always_ff @(posedge clk) begin
      if (!rst_l) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:    if (w_rise) w_next = S_RECV;
         S_RECV:    if (w_ovf) w_next = S_DROP;
                    else if (!bus.frame_act) w_next = S_FLUSH;
         S_FLUSH:   if (w_ovf) w_next = S_DROP;
                    else if (w_flush_done) w_next = r_got ? S_PUBLISH : S_IDLE;
         S_PUBLISH: w_next = S_HOLD;
         S_HOLD:    if (bus.dpr_done) w_next = S_IDLE;
         S_DROP:    if (!bus.frame_act && !r_wen) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy      = (r_state == S_FLUSH) | (r_state == S_PUBLISH) |
                      (r_state == S_HOLD)  | (r_state == S_DROP);
      bus.pkt_avail = (r_state == S_HOLD);
   end

   assign bus.mem_ptr   = r_ptr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_w_en  = r_wen;
   assign bus.pkt_begin = BUF_BASE;
   assign bus.pkt_end   = r_pkt_end;
   assign bus.ovf_err   = r_ovf;

   always_ff @(posedge clk) begin
      if (w_push && !w_ovf) r_fifo[r_wr] <= r_push_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         r_frame_d   <= 1'b0;
         r_lane      <= '0;
         r_asm       <= '0;
         r_got       <= 1'b0;
         r_push_pend <= 1'b0;
         r_push_data <= '0;
         r_wr        <= '0;
         r_rd        <= '0;
         r_cnt       <= '0;
         r_wen       <= 1'b0;
         r_ptr       <= '0;
         r_wdata     <= '0;
         r_wcount    <= '0;
         r_pkt_end   <= '0;
         r_ovf       <= 1'b0;
      end else begin
         r_frame_d   <= bus.frame_act;
         r_push_pend <= 1'b0;
         unique case (r_state)
            S_IDLE: if (w_rise) begin
               r_lane <= '0;
               r_asm  <= '0;
               r_got  <= 1'b0;
            end
            S_RECV: if (bus.rx_valid) begin
               r_got <= 1'b1;
               if (r_lane == 2'd3) begin
                  r_push_pend <= 1'b1;
                  r_push_data <= {bus.rx_byte, r_asm[23:0]};
                  r_asm       <= '0;
                  r_lane      <= '0;
               end else begin
                  r_asm[{r_lane, 3'b000} +: 8] <= bus.rx_byte;
                  r_lane <= r_lane + 2'd1;
               end
            end
            S_FLUSH: if (r_lane != 2'd0 && !r_push_pend) begin
               r_push_pend <= 1'b1;
               r_push_data <= r_asm;
               r_asm       <= '0;
               r_lane      <= '0;
            end
            S_PUBLISH: r_pkt_end <= BUF_BASE + ADDR_SIZE'(r_wcount);
            default: ;
         endcase

         if (r_state == S_DROP || w_ovf) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
         end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
         end

         if (r_wen) begin
            if (bus.mem_done) begin
               r_wen    <= 1'b0;
               r_wcount <= r_wcount + WC_W'(1);
            end
         end else if (w_pop) begin
            r_wen   <= 1'b1;
            r_ptr   <= BUF_BASE + ADDR_SIZE'(r_wcount);
            r_wdata <= r_fifo[r_rd];
         end

         if ((r_state == S_HOLD && bus.dpr_done) || (r_state == S_DROP && w_next == S_IDLE))
            r_wcount <= '0;

         if (w_ovf) r_ovf <= 1'b1;
      end
   end
endmodule

// File: tb/tb_spi_pkt_loader.sv
// Directed scenarios for spi_pkt_loader; memory writes are checked against a queue of
// words expected from the bytes sent.
module tb_spi_pkt_loader;
   localparam int unsigned AW     = 23;
   localparam logic [AW-1:0] BASE = 23'h7FFFFF;

   logic clk = 1'b0;
   logic rst_l;
   always #5 clk = ~clk;

   spi_pkt_loader_if #(.ADDR_SIZE(AW)) bus ();
   spi_pkt_loader_if #(.ADDR_SIZE(AW)) bus_b ();

   spi_pkt_loader #(.ADDR_SIZE(AW), .BUF_BASE(BASE), .BUF_WORDS(1024), .FIFO_DEPTH(4))
      dut (.clk(clk), .rst_l(rst_l), .bus(bus));
   spi_pkt_loader #(.ADDR_SIZE(AW), .BUF_BASE(23'h0), .BUF_WORDS(2), .FIFO_DEPTH(4))
      dut_b (.clk(clk), .rst_l(rst_l), .bus(bus_b));

   typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;
   wr_t exp_q[$];

   int unsigned checks = 0, errors = 0;
   int unsigned nwr = 0, nwr_b = 0, avail_cnt = 0, avail_b_cnt = 0;
   int unsigned resp_dly = 1;
   bit tgt_b = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] addr(input int unsigned i);
      return BASE + AW'(i);
   endfunction

   always @(negedge clk) begin
      if (bus.pkt_avail)   avail_cnt++;
      if (bus_b.pkt_avail) avail_b_cnt++;
   end

   initial begin : resp_main
      logic [AW-1:0] wa;
      logic [31:0]   wd;
      wr_t           e;
      bus.mem_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_l && bus.mem_w_en) begin
            wa = bus.mem_ptr;
            wd = bus.mem_wdata;
            nwr++;
            chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("wr_addr", 32'(wa), 32'(e.a));
               chk("wr_data", wd, e.d);
            end
            repeat (resp_dly) @(negedge clk);
            chk("wr_hold", 32'(bus.mem_ptr == wa && bus.mem_wdata == wd && bus.mem_w_en), 32'd1);
            bus.mem_done = 1'b1;
            @(negedge clk);
            bus.mem_done = 1'b0;
         end
      end
   end

   initial begin : resp_b
      bus_b.mem_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_l && bus_b.mem_w_en) begin
            nwr_b++;
            chk("b_wr_in_buf", 32'(bus_b.mem_ptr < 23'd2), 32'd1);
            @(negedge clk);
            bus_b.mem_done = 1'b1;
            @(negedge clk);
            bus_b.mem_done = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "simulation time limit reached");
   end

   task automatic drive_frame(input logic v);
      if (tgt_b) bus_b.frame_act = v;
      else       bus.frame_act   = v;
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      if (tgt_b) begin bus_b.rx_byte = b; bus_b.rx_valid = 1'b1; end
      else       begin bus.rx_byte   = b; bus.rx_valid   = 1'b1; end
      @(negedge clk);
      bus.rx_valid   = 1'b0;
      bus_b.rx_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b[$], input int unsigned gap);
      drive_frame(1'b1);
      repeat (2) @(negedge clk);
      foreach (b[i]) send_byte(b[i], gap);
      drive_frame(1'b0);
      @(negedge clk);
   endtask

   task automatic expect_words(input logic [7:0] b[$]);
      wr_t e;
      int unsigned n = b.size();
      for (int unsigned i = 0; i < (n + 3) / 4; i++) begin
         e.a = addr(i);
         e.d = '0;
         for (int unsigned j = 0; j < 4; j++)
            if (4 * i + j < n) e.d[8 * j +: 8] = b[4 * i + j];
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_avail(input string tag);
      int unsigned k = 0;
      while (!bus.pkt_avail && k < 400) begin @(negedge clk); k++; end
      chk(tag, 32'(bus.pkt_avail), 32'd1);
   endtask

   task automatic wait_idle(input string tag, input bit on_b);
      int unsigned k = 0;
      while ((on_b ? bus_b.busy : bus.busy) && k < 400) begin @(negedge clk); k++; end
      chk(tag, 32'(on_b ? bus_b.busy : bus.busy), 32'd0);
   endtask

   task automatic release_pkt(input string tag);
      bus.dpr_done = 1'b1;
      @(negedge clk);
      bus.dpr_done = 1'b0;
      chk({tag, "_avail_drop"}, 32'(bus.pkt_avail), 32'd0);
      chk({tag, "_busy_drop"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin : stim
      logic [7:0]  bq[$];
      int unsigned n0, a0;

      rst_l = 1'b0;
      bus.rx_byte = '0;   bus.rx_valid = 1'b0;   bus.frame_act = 1'b0;   bus.dpr_done = 1'b0;
      bus_b.rx_byte = '0; bus_b.rx_valid = 1'b0; bus_b.frame_act = 1'b0; bus_b.dpr_done = 1'b0;
      repeat (3) @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);

      chk("rst_busy",      32'(bus.busy), 32'd0);
      chk("rst_w_en",      32'(bus.mem_w_en), 32'd0);
      chk("rst_avail",     32'(bus.pkt_avail), 32'd0);
      chk("rst_ovf",       32'(bus.ovf_err), 32'd0);
      chk("rst_ptr",       32'(bus.mem_ptr), 32'd0);
      chk("rst_wdata",     bus.mem_wdata, 32'd0);
      chk("rst_pkt_begin", 32'(bus.pkt_begin), 32'(BASE));
      chk("rst_pkt_end",   32'(bus.pkt_end), 32'd0);

      // eight bytes, two full words, address wraps past the top of memory
      bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      expect_words(bq);
      send_frame(bq, 2);
      wait_avail("p8_avail");
      chk("p8_pkt_end",   32'(bus.pkt_end), 32'(addr(2)));
      chk("p8_pkt_begin", 32'(bus.pkt_begin), 32'(BASE));
      chk("p8_busy",      32'(bus.busy), 32'd1);
      chk("p8_all_wr",    32'(exp_q.size()), 32'd0);
      repeat (5) @(negedge clk);
      chk("p8_hold_avail", 32'(bus.pkt_avail), 32'd1);
      chk("p8_hold_end",   32'(bus.pkt_end), 32'(addr(2)));
      release_pkt("p8");

      // five back-to-back bytes, partial last word
      bq = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      expect_words(bq);
      send_frame(bq, 1);
      wait_avail("p5_avail");
      chk("p5_pkt_end", 32'(bus.pkt_end), 32'(addr(2)));
      chk("p5_all_wr",  32'(exp_q.size()), 32'd0);
      release_pkt("p5");

      // empty frame
      n0 = nwr; a0 = avail_cnt;
      drive_frame(1'b1);
      repeat (3) @(negedge clk);
      drive_frame(1'b0);
      repeat (10) @(negedge clk);
      chk("empty_writes", nwr, n0);
      chk("empty_avail",  avail_cnt, a0);
      chk("empty_busy",   32'(bus.busy), 32'd0);

      // frame that starts during HOLD stays ignored after the release
      bq = {8'h11, 8'h22, 8'h33, 8'h44};
      expect_words(bq);
      send_frame(bq, 2);
      wait_avail("p4_avail");
      chk("p4_pkt_end", 32'(bus.pkt_end), 32'(addr(1)));
      n0 = nwr;
      drive_frame(1'b1);
      repeat (2) @(negedge clk);
      send_byte(8'h55, 2);
      send_byte(8'h66, 2);
      chk("hold_avail_kept", 32'(bus.pkt_avail), 32'd1);
      release_pkt("hold");
      a0 = avail_cnt;
      for (int i = 0; i < 4; i++) send_byte(8'(8'h70 + i), 2);
      drive_frame(1'b0);
      repeat (20) @(negedge clk);
      chk("hold_writes", nwr, n0);
      chk("hold_avail",  avail_cnt, a0);
      chk("hold_busy",   32'(bus.busy), 32'd0);

      // slow memory, slow bytes: no error
      resp_dly = 20;
      bq.delete();
      for (int i = 0; i < 16; i++) bq.push_back(8'(i * 7 + 3));
      expect_words(bq);
      send_frame(bq, 8);
      wait_avail("slow_avail");
      chk("slow_pkt_end", 32'(bus.pkt_end), 32'(addr(4)));
      chk("slow_ovf",     32'(bus.ovf_err), 32'd0);
      chk("slow_all_wr",  32'(exp_q.size()), 32'd0);
      release_pkt("slow");

      // slow memory, fast bytes: FIFO overrun
      bq.delete();
      for (int i = 0; i < 48; i++) bq.push_back(8'(i + 8'h80));
      expect_words(bq);
      a0 = avail_cnt;
      send_frame(bq, 2);
      wait_idle("ovr_idle", 1'b0);
      chk("ovr_ovf",        32'(bus.ovf_err), 32'd1);
      chk("ovr_avail",      avail_cnt, a0);
      chk("ovr_some_unwr",  32'(exp_q.size() != 0), 32'd1);
      chk("ovr_w_en",       32'(bus.mem_w_en), 32'd0);
      exp_q.delete();
      resp_dly = 1;

      // two-word buffer, twelve bytes
      tgt_b = 1'b1;
      bq.delete();
      for (int i = 0; i < 12; i++) bq.push_back(8'(i + 1));
      send_frame(bq, 2);
      wait_idle("b_idle", 1'b1);
      tgt_b = 1'b0;
      chk("b_ovf",    32'(bus_b.ovf_err), 32'd1);
      chk("b_writes", nwr_b, 32'd2);
      chk("b_avail",  avail_b_cnt, 32'd0);

      // reset in the middle of a frame
      drive_frame(1'b1);
      repeat (2) @(negedge clk);
      send_byte(8'h99, 2);
      send_byte(8'h98, 2);
      rst_l = 1'b0;
      drive_frame(1'b0);
      @(negedge clk);
      chk("mrst_busy",      32'(bus.busy), 32'd0);
      chk("mrst_w_en",      32'(bus.mem_w_en), 32'd0);
      chk("mrst_avail",     32'(bus.pkt_avail), 32'd0);
      chk("mrst_ovf",       32'(bus.ovf_err), 32'd0);
      chk("mrst_pkt_end",   32'(bus.pkt_end), 32'd0);
      chk("mrst_pkt_begin", 32'(bus.pkt_begin), 32'(BASE));
      chk("mrst_b_ovf",     32'(bus_b.ovf_err), 32'd0);
      rst_l = 1'b1;
      @(negedge clk);
      bq = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
      expect_words(bq);
      send_frame(bq, 2);
      wait_avail("post_avail");
      chk("post_pkt_end", 32'(bus.pkt_end), 32'(addr(1)));
      chk("post_all_wr",  32'(exp_q.size()), 32'd0);
      release_pkt("post");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
